// File: rtl/adc_pattern_checker.sv
// rtl/adc_pattern_checker.sv - ADC test-pattern checker (ramp/fixed/toggle) with one-cycle data forwarding.
// Define ADC_CHK_FIRSTERR_EN to add first-mismatch capture outputs.
module adc_pattern_checker #(
  parameter int pDATA_WIDTH   = 12,
  parameter int pERRCNT_WIDTH = 16,
  parameter int pSMPCNT_WIDTH = 32,
  parameter int pLOCK_COUNT   = 64
) (
  input  logic                     clk_adc,
  input  logic                     reset_n,
  input  logic [pDATA_WIDTH-1:0]   adc_data_i,
  output logic [pDATA_WIDTH-1:0]   adc_data_o,
  input  logic                     check_en,
  input  logic [1:0]               check_mode,
  input  logic [pDATA_WIDTH-1:0]   fixed_pattern,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic [pERRCNT_WIDTH-1:0] err_count_o,
  output logic [pSMPCNT_WIDTH-1:0] sample_count_o,
`ifdef ADC_CHK_FIRSTERR_EN
  output logic                     first_err_valid_o,
  output logic [pDATA_WIDTH-1:0]   first_err_expected_o,
  output logic [pDATA_WIDTH-1:0]   first_err_actual_o,
`endif
  output logic [1:0]               state_o
);

  localparam int RUN_W = $clog2(pLOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_VAL = RUN_W'(pLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SEED  = 2'b01,
    ST_CHECK = 2'b10
  } state_t;

  state_t                   state, state_nxt;
  logic [pDATA_WIDTH-1:0]   d1;
  logic [pDATA_WIDTH-1:0]   expected;
  logic [1:0]               mode_q;
  logic [RUN_W-1:0]         run_cnt;
  logic [RUN_W-1:0]         run_inc;
  logic [pDATA_WIDTH-1:0]   seed_val;
  logic [pDATA_WIDTH-1:0]   next_exp;
  logic                     enabled;
  logic                     mode_changed;
  logic                     match;
  logic                     do_seed;
  logic                     do_cmp;

  assign adc_data_o   = d1;
  assign state_o      = state;
  assign enabled      = check_en && (check_mode != 2'b11);
  assign mode_changed = (check_mode != mode_q);
  assign match        = (d1 == expected);
  assign run_inc      = (run_cnt == LOCK_VAL) ? run_cnt : run_cnt + RUN_W'(1);

  always_comb begin
    seed_val = fixed_pattern;
    next_exp = fixed_pattern;
    case (check_mode)
      2'b00: begin
        seed_val = d1 + pDATA_WIDTH'(1);
        next_exp = seed_val;
      end
      2'b10: begin
        seed_val = (d1 == fixed_pattern) ? ~fixed_pattern : fixed_pattern;
        next_exp = ~expected;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // clear beats disable, which beats a mode change, which beats a normal compare
  always_comb begin
    state_nxt = state;
    do_seed   = 1'b0;
    do_cmp    = 1'b0;
    if (clear_i) begin
      state_nxt = enabled ? ST_SEED : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (enabled) state_nxt = ST_SEED;
        ST_SEED: begin
          if (!enabled)          state_nxt = ST_IDLE;
          else if (mode_changed) state_nxt = ST_SEED;
          else begin
            do_seed   = 1'b1;
            state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!enabled)          state_nxt = ST_IDLE;
          else if (mode_changed) state_nxt = ST_SEED;
          else                   do_cmp = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      d1             <= '0;
      mode_q         <= '0;
      expected       <= '0;
      run_cnt        <= '0;
      locked_o       <= 1'b0;
      err_count_o    <= '0;
      sample_count_o <= '0;
`ifdef ADC_CHK_FIRSTERR_EN
      first_err_valid_o    <= 1'b0;
      first_err_expected_o <= '0;
      first_err_actual_o   <= '0;
`endif
    end else begin
      d1     <= adc_data_i;
      mode_q <= check_mode;
      if (clear_i) begin
        run_cnt        <= '0;
        locked_o       <= 1'b0;
        err_count_o    <= '0;
        sample_count_o <= '0;
`ifdef ADC_CHK_FIRSTERR_EN
        first_err_valid_o    <= 1'b0;
        first_err_expected_o <= '0;
        first_err_actual_o   <= '0;
`endif
      end else if (do_seed) begin
        expected <= seed_val;
        run_cnt  <= '0;
        locked_o <= 1'b0;
      end else if (do_cmp) begin
        if (sample_count_o != {pSMPCNT_WIDTH{1'b1}})
          sample_count_o <= sample_count_o + pSMPCNT_WIDTH'(1);
        if (match) begin
          run_cnt  <= run_inc;
          locked_o <= (run_inc == LOCK_VAL);
          expected <= next_exp;
        end else begin
          // re-seed from the offending word so a single slip is counted once
          run_cnt  <= '0;
          locked_o <= 1'b0;
          expected <= seed_val;
          if (err_count_o != {pERRCNT_WIDTH{1'b1}})
            err_count_o <= err_count_o + pERRCNT_WIDTH'(1);
`ifdef ADC_CHK_FIRSTERR_EN
          if (!first_err_valid_o) begin
            first_err_valid_o    <= 1'b1;
            first_err_expected_o <= expected;
            first_err_actual_o   <= d1;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_pattern_checker.sv
// tb/tb_adc_pattern_checker.sv - directed self-checking bench for adc_pattern_checker.
module tb_adc_pattern_checker;

  logic        clk_adc = 1'b0;
  logic        reset_n = 1'b1;
  logic [11:0] adc_data_i = '0;
  logic        check_en = 1'b0;
  logic [1:0]  check_mode = 2'b00;
  logic [11:0] fixed_pattern = '0;
  logic        clear_i = 1'b0;

  logic [11:0] adc_data_o, adc_data_o_s;
  logic        locked_o, locked_o_s;
  logic [15:0] err_count_o;
  logic [3:0]  err_count_s;
  logic [31:0] sample_count_o, sample_count_s;
  logic [1:0]  state_o, state_s;
`ifdef ADC_CHK_FIRSTERR_EN
  logic        fe_valid, fe_valid_s;
  logic [11:0] fe_exp, fe_exp_s, fe_act, fe_act_s;
`endif

  int checks = 0;
  int failures = 0;

  adc_pattern_checker dut (
    .clk_adc(clk_adc), .reset_n(reset_n), .adc_data_i(adc_data_i), .adc_data_o(adc_data_o),
    .check_en(check_en), .check_mode(check_mode), .fixed_pattern(fixed_pattern),
    .clear_i(clear_i), .locked_o(locked_o), .err_count_o(err_count_o),
    .sample_count_o(sample_count_o),
`ifdef ADC_CHK_FIRSTERR_EN
    .first_err_valid_o(fe_valid), .first_err_expected_o(fe_exp), .first_err_actual_o(fe_act),
`endif
    .state_o(state_o)
  );

  adc_pattern_checker #(.pERRCNT_WIDTH(4)) dut_sat (
    .clk_adc(clk_adc), .reset_n(reset_n), .adc_data_i(adc_data_i), .adc_data_o(adc_data_o_s),
    .check_en(check_en), .check_mode(check_mode), .fixed_pattern(fixed_pattern),
    .clear_i(clear_i), .locked_o(locked_o_s), .err_count_o(err_count_s),
    .sample_count_o(sample_count_s),
`ifdef ADC_CHK_FIRSTERR_EN
    .first_err_valid_o(fe_valid_s), .first_err_expected_o(fe_exp_s), .first_err_actual_o(fe_act_s),
`endif
    .state_o(state_s)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic tick(input logic [11:0] w);
    adc_data_i = w;
    @(posedge clk_adc);
    #1;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk_adc);
    #1;
    checks++; if (state_o !== 2'b00) begin failures++; $display("FAIL reset_state got %0h exp 0", state_o); end
    checks++; if (err_count_o !== 16'd0) begin failures++; $display("FAIL reset_err got %0d exp 0", err_count_o); end
    checks++; if (sample_count_o !== 32'd0) begin failures++; $display("FAIL reset_smp got %0d exp 0", sample_count_o); end
    checks++; if (locked_o !== 1'b0 || adc_data_o !== 12'h000) begin failures++; $display("FAIL reset_lock_data got %0b/%0h exp 0/0", locked_o, adc_data_o); end
    reset_n = 1'b1;
    tick(12'h000);
  endtask

  task automatic test_ramp;
    check_mode = 2'b00;
    check_en   = 1'b1;
    tick(12'd0);
    checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL ramp_seed_state got %0h exp 1", state_o); end
    tick(12'd1);
    checks++; if (state_o !== 2'b10 || sample_count_o !== 32'd0) begin failures++; $display("FAIL ramp_check_state got %0h/%0d exp 2/0", state_o, sample_count_o); end
    for (int w = 2; w <= 300; w++) begin
      tick(12'(w));
      if (w == 64) begin
        checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL ramp_lock63 got %0b exp 0", locked_o); end
      end
      if (w == 65) begin
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL ramp_lock64 got %0b exp 1", locked_o); end
      end
    end
    check_en = 1'b0;
    tick(12'd301);
    checks++; if (sample_count_o !== 32'd299) begin failures++; $display("FAIL ramp_samples got %0d exp 299", sample_count_o); end
    checks++; if (err_count_o !== 16'd0) begin failures++; $display("FAIL ramp_err got %0d exp 0", err_count_o); end
    checks++; if (state_o !== 2'b00 || locked_o !== 1'b1) begin failures++; $display("FAIL ramp_idle_hold got %0h/%0b exp 0/1", state_o, locked_o); end
  endtask

  task automatic test_ramp_jump;
    logic [11:0] w;
    check_mode = 2'b00;
    check_en   = 1'b1;
    clear_i    = 1'b1;
    tick(12'd0);
    clear_i = 1'b0;
    checks++; if (state_o !== 2'b01 || sample_count_o !== 32'd0 || locked_o !== 1'b0) begin failures++; $display("FAIL jump_clear got %0h/%0d/%0b exp 1/0/0", state_o, sample_count_o, locked_o); end
    tick(12'd1);
    for (int i = 2; i <= 200; i++) begin
      w = (i <= 100) ? 12'(i) : 12'(i + 4);
      tick(w);
      if (i == 101) begin
        checks++; if (locked_o !== 1'b1 || err_count_o !== 16'd0) begin failures++; $display("FAIL jump_pre got %0b/%0d exp 1/0", locked_o, err_count_o); end
      end
      if (i == 102) begin
        checks++; if (locked_o !== 1'b0 || err_count_o !== 16'd1) begin failures++; $display("FAIL jump_hit got %0b/%0d exp 0/1", locked_o, err_count_o); end
      end
      if (i == 165) begin
        checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL jump_relock63 got %0b exp 0", locked_o); end
      end
      if (i == 166) begin
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL jump_relock64 got %0b exp 1", locked_o); end
      end
    end
    checks++; if (err_count_o !== 16'd1 || sample_count_o !== 32'd199) begin failures++; $display("FAIL jump_final got %0d/%0d exp 1/199", err_count_o, sample_count_o); end
    check_en = 1'b0;
    tick(12'd0);
  endtask

  task automatic test_fixed;
    logic [11:0] seq [9];
    seq = '{12'hA5A, 12'hA5A, 12'hA5A, 12'hA5B, 12'hA5A, 12'hA5A, 12'h000, 12'hA5A, 12'hA5A};
    check_mode    = 2'b01;
    fixed_pattern = 12'hA5A;
    check_en      = 1'b1;
    clear_i       = 1'b1;
    tick(12'hA5A);
    clear_i = 1'b0;
    for (int i = 0; i <= 9; i++) begin
      tick(i < 9 ? seq[i] : 12'hA5A);
      if (i == 3) begin
        checks++; if (err_count_o !== 16'd0) begin failures++; $display("FAIL fixed_pre got %0d exp 0", err_count_o); end
      end
      if (i == 4) begin
        checks++; if (err_count_o !== 16'd1) begin failures++; $display("FAIL fixed_err1 got %0d exp 1", err_count_o); end
`ifdef ADC_CHK_FIRSTERR_EN
        checks++; if (fe_valid !== 1'b1 || fe_exp !== 12'hA5A || fe_act !== 12'hA5B) begin failures++; $display("FAIL fixed_capture got %0b/%0h/%0h exp 1/a5a/a5b", fe_valid, fe_exp, fe_act); end
`endif
      end
    end
    checks++; if (err_count_o !== 16'd2 || sample_count_o !== 32'd9) begin failures++; $display("FAIL fixed_final got %0d/%0d exp 2/9", err_count_o, sample_count_o); end
`ifdef ADC_CHK_FIRSTERR_EN
    checks++; if (fe_valid !== 1'b1 || fe_exp !== 12'hA5A || fe_act !== 12'hA5B) begin failures++; $display("FAIL fixed_capture_hold got %0b/%0h/%0h exp 1/a5a/a5b", fe_valid, fe_exp, fe_act); end
`endif
  endtask

  task automatic test_toggle;
    logic [11:0] seq [8];
    seq = '{12'hAAA, 12'h555, 12'hAAA, 12'h555, 12'h555, 12'hAAA, 12'h555, 12'hAAA};
    check_mode    = 2'b10;
    fixed_pattern = 12'h555;
    check_en      = 1'b1;
    clear_i       = 1'b1;
    tick(12'h555);
    clear_i = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      tick(i < 8 ? seq[i] : 12'h555);
      if (i == 4) begin
        checks++; if (err_count_o !== 16'd0) begin failures++; $display("FAIL toggle_pre got %0d exp 0", err_count_o); end
      end
      if (i == 5) begin
        checks++; if (err_count_o !== 16'd1) begin failures++; $display("FAIL toggle_err got %0d exp 1", err_count_o); end
      end
    end
    checks++; if (err_count_o !== 16'd1 || sample_count_o !== 32'd8) begin failures++; $display("FAIL toggle_final got %0d/%0d exp 1/8", err_count_o, sample_count_o); end
  endtask

  task automatic test_saturate_clear;
    check_mode    = 2'b01;
    fixed_pattern = 12'hA5A;
    check_en      = 1'b1;
    clear_i       = 1'b1;
    tick(12'h000);
    clear_i = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      tick(12'h000);
      if (i == 15) begin
        checks++; if (err_count_s !== 4'd15 || err_count_o !== 16'd15) begin failures++; $display("FAIL sat_reach got %0d/%0d exp 15/15", err_count_s, err_count_o); end
      end
    end
    checks++; if (err_count_s !== 4'd15 || err_count_o !== 16'd20) begin failures++; $display("FAIL sat_hold got %0d/%0d exp 15/20", err_count_s, err_count_o); end
    clear_i = 1'b1;
    tick(12'h000);
    clear_i = 1'b0;
    checks++; if (err_count_s !== 4'd0 || err_count_o !== 16'd0 || sample_count_o !== 32'd0) begin failures++; $display("FAIL sat_clear got %0d/%0d/%0d exp 0/0/0", err_count_s, err_count_o, sample_count_o); end
    checks++; if (state_o !== 2'b01) begin failures++; $display("FAIL sat_clear_state got %0h exp 1", state_o); end
  endtask

  task automatic test_reset_mid_check;
    tick(12'h000);
    tick(12'h000);
    tick(12'h000);
    checks++; if (state_o !== 2'b10 || err_count_o !== 16'd2) begin failures++; $display("FAIL midrst_pre got %0h/%0d exp 2/2", state_o, err_count_o); end
    reset_n = 1'b0;
    #2;
    checks++; if (state_o !== 2'b00 || err_count_o !== 16'd0 || sample_count_o !== 32'd0 || locked_o !== 1'b0 || adc_data_o !== 12'h000) begin
      failures++; $display("FAIL midrst_async got %0h/%0d/%0d/%0b/%0h exp all 0", state_o, err_count_o, sample_count_o, locked_o, adc_data_o);
    end
    tick(12'h123);
    reset_n = 1'b1;
    #2;
    checks++; if (adc_data_o !== 12'h000) begin failures++; $display("FAIL midrst_release got %0h exp 0", adc_data_o); end
    @(posedge clk_adc);
    #1;
    checks++; if (adc_data_o !== 12'h123 || state_o !== 2'b01) begin failures++; $display("FAIL midrst_after got %0h/%0h exp 123/1", adc_data_o, state_o); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_ramp_jump();
    test_fixed();
    test_toggle();
    test_saturate_clear();
    test_reset_mid_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
